hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard/forwarding controller for the pipelined ARM-subset CPU. It sits beside the RF (decode) stage. It keeps a shift-register scoreboard of the destination registers in flight in the DEPTH stages downstream of RF. It issues per-operand forwarding selects, load-use stalls with bubble insertion, flag-forwarding, and branch-flush handling. This generalises the fixed two-source, EX/MEM-only forwarding logic to arbitrary pipeline depth, operand count and load latency, and adds stall generation.

## Interface
Parameters:
- REG_W, 5, register address width
- NSRC, 2, source operands per instruction
- DEPTH, 3, scoreboard entries (entry 0 = EX, 1 = MEM, 2 = WB, ...)
- LOAD_STAGE, 1, first entry index whose load result is forwardable
- ZERO_REG, 31, hard-zero register; never forwarded, never hazards
- CNT_W, 16, stall counter width
- SEL_W, $clog2(DEPTH+1), forward-select width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  RF stage holds a valid instruction
- src_addr  in  NSRC*REG_W  source register addresses; operand i at [i*REG_W +: REG_W]
- src_used  in  NSRC  operand i is actually read
- dst_addr  in  REG_W  destination register of RF instruction
- dst_wr  in  1  RF instruction writes dst_addr
- dst_is_load  in  1  RF instruction is a load
- sets_flags  in  1  RF instruction updates NZVC
- uses_flags  in  1  RF instruction reads NZVC (conditional branch)
- flush  in  1  taken branch; kill RF instruction
- fwd_sel  out  NSRC*SEL_W  per operand: 0 = register file, k+1 = result of entry k
- flag_fwd  out  1  take flags from the live EX ALU outputs, not the flag register
- stall  out  1  hold PC and IF/RF register; bubble into EX
- stall_cnt  out  CNT_W  stall cycle counter (STALL_CNT_EN only)

## Operation
- Each scoreboard entry holds {valid, wr, addr, is_load, setf}.
- Every clock, entries shift: entry[k] <= entry[k-1] for k≥1. Shifts are never held.
- entry[0] is loaded with the RF instruction when issue_valid & ~stall & ~flush. Otherwise entry[0] gets a bubble (valid=0).
- Match for operand i: src_used[i], src_addr ≠ ZERO_REG, and entry valid & wr & addr == src_addr. The youngest match (lowest k) wins.
- fwd_sel[i] = k+1 for the winning k. With no match, fwd_sel[i] = 0.
- Load-use hazard: the winning entry has is_load and k < LOAD_STAGE.
- Flag hazard: uses_flags & entry[0].valid & entry[0].setf gives flag_fwd=1. Deeper setters have already committed to the flag register.
- stall = issue_valid & ~flush & ~reset & (any operand load-use hazard).
- flush has priority over stall. A flushed instruction never stalls and never enters the scoreboard.
- While stalled, fwd_sel still reflects the current match. The value is don't-care to the datapath.

## Timing
- fwd_sel, flag_fwd and stall are combinational from the registered scoreboard plus current inputs. Same-cycle, zero latency.
- Load-use with LOAD_STAGE=1: exactly one stall cycle. In the next cycle the load sits in entry 1 and fwd_sel = 2.
- A load-use stall lasts LOAD_STAGE−k cycles for a winning entry k.
- On reset: all entries invalid and stall_cnt = 0. Outputs fwd_sel=0, flag_fwd=0 and stall=0, both during reset and on the first cycle after it.
- Reset mid-stall: the stall drops in the same cycle and the scoreboard clears at the next edge.
- A writer to ZERO_REG may enter the scoreboard but never matches.
- Simultaneous flush and load-use: stall=0, and a bubble enters entry 0.

## Configuration
- Macro HAZARD_SCOREBOARD_STALL_CNT_EN.
- When defined: stall_cnt increments by 1 each cycle stall=1 and saturates at 2^CNT_W−1.
- When undefined: the counter logic is omitted and stall_cnt is tied to 0.

## Test plan
- ADD X1 issued, then ADD X2,X1,X1 next cycle -> fwd_sel op0 = op1 = 1, stall=0.
- LDUR X3 issued, then ADD X4,X3,X5 -> stall=1 for one cycle with a bubble in entry 0. Next cycle fwd_sel op0 = 2, op1 = 0, stall=0.
- ADD X31 (writer) followed by a read of X31 -> fwd_sel=0, stall=0.
- X5 written at entry 1 and entry 0 simultaneously (two back-to-back writers) -> fwd_sel=1, the youngest.
- SUBS followed by B.LT -> flag_fwd=1. With one instruction between them -> flag_fwd=0.
- LDUR X6 then ADD X7,X6 with flush=1 in the same cycle -> stall=0, entry 0 bubble.
- With CNT_W=2, 5 load-use stalls -> stall_cnt = 3 (saturated). A reset pulse returns it to 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard / forwarding controller that sits beside the RF (decode) stage.
//   It keeps a shift-register scoreboard of the destinations in flight in the
//   DEPTH stages below RF (entry 0 = EX, 1 = MEM, ...). From that it produces
//   per-operand forwarding selects, load-use stalls (bubble into EX), EX flag
//   forwarding and branch-flush handling.
//
//   Optional feature: define HAZARD_SCOREBOARD_STALL_CNT_EN to build a
//   saturating stall-cycle counter. When it is undefined, stall_cnt is tied to 0.
//
// Ports
//   clk          clock, all state on posedge
//   reset        synchronous, active-high
//   issue_valid  RF stage holds a valid instruction
//   src_addr     NSRC source addresses, operand i at [i*REG_W +: REG_W]
//   src_used     operand i is actually read
//   dst_addr     destination of the RF instruction
//   dst_wr       RF instruction writes dst_addr
//   dst_is_load  RF instruction is a load
//   sets_flags   RF instruction updates NZVC
//   uses_flags   RF instruction reads NZVC
//   flush        taken branch, kill the RF instruction
//   fwd_sel      per operand: 0 = register file, k+1 = result of entry k
//   flag_fwd     take flags from the live EX ALU outputs
//   stall        hold PC and IF/RF, insert a bubble into EX
//   stall_cnt    stall cycle counter

// Per-operand match against the scoreboard. The youngest matching entry wins.
module hazard_src_match #(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int ZERO_REG   = 31,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                        used,
    input  logic [REG_W-1:0]            addr,
    input  logic [DEPTH-1:0]            ent_vld,
    input  logic [DEPTH-1:0]            ent_wr,
    input  logic [DEPTH-1:0]            ent_ld,
    input  logic [DEPTH-1:0][REG_W-1:0] ent_addr,
    output logic [SEL_W-1:0]            sel,
    output logic                        hazard
);
    always_comb begin
        sel    = '0;
        hazard = 1'b0;
        if (used && addr != REG_W'(ZERO_REG)) begin
            // Walk oldest to youngest so that the youngest match overwrites.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_vld[k] && ent_wr[k] && ent_addr[k] == addr) begin
                    sel    = SEL_W'(k + 1);
                    hazard = ent_ld[k] && (k < LOAD_STAGE);
                end
            end
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int REG_W      = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int ZERO_REG   = 31,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [NSRC*REG_W-1:0]  src_addr,
    input  logic [NSRC-1:0]        src_used,
    input  logic [REG_W-1:0]       dst_addr,
    input  logic                   dst_wr,
    input  logic                   dst_is_load,
    input  logic                   sets_flags,
    input  logic                   uses_flags,
    input  logic                   flush,
    output logic [NSRC*SEL_W-1:0]  fwd_sel,
    output logic                   flag_fwd,
    output logic                   stall,
    output logic [CNT_W-1:0]       stall_cnt
);
    // Scoreboard, one bit-vector per field, index = entry.
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0]            wr_pipe;
    logic [DEPTH-1:0]            ld_pipe;
    logic [DEPTH-1:0]            setf_pipe;
    logic [DEPTH-1:0][REG_W-1:0] addr_pipe;

    logic [NSRC-1:0][SEL_W-1:0]  sel_raw;
    logic [NSRC-1:0]             lu_haz;

    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_src
            hazard_src_match #(
                .REG_W(REG_W), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE),
                .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
            ) u_match (
                .used    (src_used[i]),
                .addr    (src_addr[i*REG_W +: REG_W]),
                .ent_vld (vld_pipe),
                .ent_wr  (wr_pipe),
                .ent_ld  (ld_pipe),
                .ent_addr(addr_pipe),
                .sel     (sel_raw[i]),
                .hazard  (lu_haz[i])
            );
            // Gated by reset so a scoreboard that has not cleared yet cannot leak.
            assign fwd_sel[i*SEL_W +: SEL_W] = reset ? '0 : sel_raw[i];
        end
    endgenerate

    // Flush wins over stall: a killed instruction never waits.
    assign stall    = issue_valid & ~flush & ~reset & (|lu_haz);
    // Only the EX setter is not yet in the flag register.
    assign flag_fwd = ~reset & uses_flags & vld_pipe[0] & setf_pipe[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            wr_pipe   <= '0;
            ld_pipe   <= '0;
            setf_pipe <= '0;
            addr_pipe <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                wr_pipe[k]   <= wr_pipe[k-1];
                ld_pipe[k]   <= ld_pipe[k-1];
                setf_pipe[k] <= setf_pipe[k-1];
                addr_pipe[k] <= addr_pipe[k-1];
            end
            // Stall or flush: a bubble enters EX.
            vld_pipe[0]  <= issue_valid & ~stall & ~flush;
            wr_pipe[0]   <= dst_wr;
            ld_pipe[0]   <= dst_is_load;
            setf_pipe[0] <= sets_flags;
            addr_pipe[0] <= dst_addr;
        end
    end

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (stall && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end
    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
